controle_porta_elevador: RTL and testbench
==========================================

# controle_porta_elevador

Door sequencing controller for the elevator: it drives the `control_port` command of the door-animation block (LED bar plus `port_a`/`port_f` indicators) and consumes those indicators as its door-position feedback. It receives open requests from the main elevator FSM and the cabin buttons, holds the door open for a dwell time, closes it, and reverses on an obstacle. It grants `porta_liberada` to the motion logic only when the door is confirmed closed, and it traps into a fail-safe error state if the door does not reach its end position in time.

## Interface
Parameters:
- TEMPO_ABERTA, 8, dwell cycles the door stays fully open (≥1).
- TEMPO_LIMITE, 16, maximum cycles allowed in ABRINDO or FECHANDO before error (≥2).

Ports:
- clock_in  in  1  the block's only clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pedido_abrir  in  1  one-cycle open request from the main elevator FSM on arrival at a floor.
- botao_abrir  in  1  cabin open button, level.
- botao_fechar  in  1  cabin close button, level.
- obstaculo  in  1  door-path obstacle sensor, level, 1 = blocked.
- port_a  in  1  door-fully-open indicator from the animation block.
- port_f  in  1  door-fully-closed indicator from the animation block.
- control_port  out  1  door command: 1 = close, 0 = open.
- porta_liberada  out  1  1 = door confirmed closed, cabin may move.
- erro  out  1  sticky watchdog fault.
- estado  out  3  current state code.

## Operation
- States and codes: FECHADA=0, ABRINDO=1, ABERTA=2, FECHANDO=3, ERRO=4.
- Moore outputs, all registered from state:
  - control_port = 1 in FECHADA and FECHANDO, 0 otherwise.
  - porta_liberada = 1 only in FECHADA.
  - erro = 1 only in ERRO.
- Counters:
  - `tempo`: dwell counter, loaded with TEMPO_ABERTA-1.
  - `vigia`: watchdog counter, cleared on every entry to ABRINDO or FECHANDO, including a reversal.
  - Each counter is $clog2(max(TEMPO_ABERTA, TEMPO_LIMITE))+1 bits wide. Counters saturate; they never wrap.
- FECHADA:
  - pedido_abrir or botao_abrir → ABRINDO.
  - Else port_f == 0 (door lost closed) → FECHANDO.
- ABRINDO:
  - port_a == 1 → ABERTA, load `tempo`.
  - Else `vigia` == TEMPO_LIMITE-1 → ERRO.
  - Else `vigia`++.
- ABERTA, priority high→low:
  - obstaculo, botao_abrir, or pedido_abrir → reload `tempo`, stay.
  - botao_fechar → FECHANDO immediately.
  - `tempo` == 0 → FECHANDO.
  - Else `tempo`--.
- FECHANDO, priority high→low:
  - obstaculo, botao_abrir, or pedido_abrir → ABRINDO (reversal).
  - port_f == 1 → FECHADA.
  - `vigia` == TEMPO_LIMITE-1 → ERRO.
  - Else `vigia`++.
- ERRO: absorbing. Door is commanded open (control_port=0). Only reset_n exits.
- port_a and port_f are both 1 (illegal): in ABRINDO, treat as port_a. In FECHANDO, treat as port_f. No other check.

## Timing
- Reset (asynchronous assert, any state, including mid-ABRINDO/FECHANDO):
  - Next state is FECHANDO.
  - Outputs: control_port=1, porta_liberada=0, erro=0, estado=3.
  - `tempo`=0, `vigia`=0.
  - The door is driven closed after every reset.
- Reset release: first transition evaluated on the first clock_in rising edge with reset_n=1.
- Input-to-output latency: an input sampled at edge N appears on the outputs after edge N (one cycle, registered). There is no combinational path from inputs to outputs.
- ABERTA dwell with no events: exactly TEMPO_ABERTA cycles from entry to the FECHANDO transition.
- botao_fechar in ABERTA: FECHANDO on the next edge, regardless of `tempo`.
- Watchdog: ERRO is entered on the TEMPO_LIMITE-th edge spent in ABRINDO/FECHANDO without the expected indicator.
- Simultaneous pedido_abrir and botao_fechar in FECHADA: opens. In ABERTA: the reload wins.
- pedido_abrir is a single-cycle pulse; no handshake and no acknowledge. A pulse arriving in ERRO is ignored.

## Test plan
- Reset while FECHADA with port_f=1 → estado=3, control_port=1, porta_liberada=0. One edge after release → estado=0, porta_liberada=1.
- Defaults, animation model asserting port_a 4 cycles after control_port=0 and port_f 4 cycles after control_port=1. Pulse pedido_abrir in FECHADA → ABRINDO, ABERTA for exactly 8 cycles, FECHANDO, FECHADA; porta_liberada=0 throughout.
- In ABERTA at `tempo`=2, hold obstaculo for 5 cycles → no close. After release, a full 8-cycle dwell follows. botao_fechar at `tempo`=6 → FECHANDO next edge.
- In FECHANDO, 2 cycles in, assert obstaculo → ABRINDO next edge, control_port=0, `vigia` restarted at 0.
- Hold port_a=0 forever after an open request → ERRO on the 16th edge in ABRINDO, erro=1, control_port=0. Later pedido_abrir/botao inputs have no effect. reset_n low → estado=3, erro=0.
- Assert reset_n low mid-ABERTA with `tempo`=5 → outputs change asynchronously, without waiting for a clock: control_port=1, porta_liberada=0, estado=3.

Source files
------------

// File: rtl/controle_porta_elevador.sv
// rtl/controle_porta_elevador.sv - elevator door sequencing controller with dwell timer and watchdog
//
// Sequences the elevator door: opens on a floor-arrival pulse or the cabin
// open button, holds it open for a dwell time, closes it, reverses on an
// obstacle, and grants cabin motion only while the door is confirmed closed.
// A watchdog traps the controller into a fail-safe error state when the door
// does not reach its end position in time.
//
// Ports:
//   clock_in        clock, rising edge
//   reset_n         asynchronous active-low reset
//   pedido_abrir    one-cycle open request from the main elevator FSM
//   botao_abrir     cabin open button (level)
//   botao_fechar    cabin close button (level)
//   obstaculo       door-path obstacle sensor (level, 1 = blocked)
//   port_a          door-fully-open indicator
//   port_f          door-fully-closed indicator
//   control_port    door command, 1 = close, 0 = open
//   porta_liberada  1 = door confirmed closed, cabin may move
//   erro            sticky watchdog fault
//   estado          current state code
module controle_porta_elevador #(
    parameter int TEMPO_ABERTA = 8,
    parameter int TEMPO_LIMITE = 16
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       pedido_abrir,
    input  logic       botao_abrir,
    input  logic       botao_fechar,
    input  logic       obstaculo,
    input  logic       port_a,
    input  logic       port_f,
    output logic       control_port,
    output logic       porta_liberada,
    output logic       erro,
    output logic [2:0] estado
);

    localparam int TMAX = (TEMPO_ABERTA > TEMPO_LIMITE) ? TEMPO_ABERTA : TEMPO_LIMITE;
    localparam int W    = $clog2(TMAX) + 1;

    localparam logic [W-1:0] TEMPO_CARGA = W'(TEMPO_ABERTA - 1);
    localparam logic [W-1:0] VIGIA_FIM   = W'(TEMPO_LIMITE - 1);
    localparam logic [W-1:0] UM          = W'(1);

    typedef enum logic [2:0] {
        FECHADA  = 3'd0,
        ABRINDO  = 3'd1,
        ABERTA   = 3'd2,
        FECHANDO = 3'd3,
        ERRO     = 3'd4
    } estado_t;

    estado_t        state, state_next;
    logic [W-1:0]   tempo, tempo_next;
    logic [W-1:0]   vigia, vigia_next;
    logic [W-1:0]   tempo_dec, vigia_inc;
    logic           pedido_any, reabrir;
    logic           cp_next, lib_next, erro_next;

    assign pedido_any = pedido_abrir | botao_abrir;
    // Any event that must keep the door open or reverse a closing door.
    assign reabrir    = pedido_any | obstaculo;

    // Both counters saturate instead of wrapping.
    assign tempo_dec = (tempo == '0) ? tempo : tempo - UM;
    assign vigia_inc = (vigia == '1) ? vigia : vigia + UM;

    always_comb begin
        state_next = state;
        tempo_next = tempo;
        vigia_next = vigia;
        case (state)
            FECHADA: begin
                if (pedido_any) begin
                    state_next = ABRINDO;
                    vigia_next = '0;
                end else if (!port_f) begin
                    // Door drifted away from closed: drive it shut again.
                    state_next = FECHANDO;
                    vigia_next = '0;
                end
            end
            ABRINDO: begin
                // port_a wins even if port_f is also (illegally) set.
                if (port_a) begin
                    state_next = ABERTA;
                    tempo_next = TEMPO_CARGA;
                end else if (vigia == VIGIA_FIM) begin
                    state_next = ERRO;
                end else begin
                    vigia_next = vigia_inc;
                end
            end
            ABERTA: begin
                if (reabrir) begin
                    tempo_next = TEMPO_CARGA;
                end else if (botao_fechar || tempo == '0) begin
                    state_next = FECHANDO;
                    vigia_next = '0;
                end else begin
                    tempo_next = tempo_dec;
                end
            end
            FECHANDO: begin
                if (reabrir) begin
                    state_next = ABRINDO;
                    vigia_next = '0;
                end else if (port_f) begin
                    state_next = FECHADA;
                end else if (vigia == VIGIA_FIM) begin
                    state_next = ERRO;
                end else begin
                    vigia_next = vigia_inc;
                end
            end
            ERRO: begin
                state_next = ERRO;
            end
            default: begin
                state_next = ERRO;
            end
        endcase
    end

    // Outputs are registered from the next state so they change together
    // with estado and never combinationally follow the inputs.
    always_comb begin
        cp_next   = (state_next == FECHADA) || (state_next == FECHANDO);
        lib_next  = (state_next == FECHADA);
        erro_next = (state_next == ERRO);
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            // Every reset drives the door closed before granting motion.
            state          <= FECHANDO;
            tempo          <= '0;
            vigia          <= '0;
            control_port   <= 1'b1;
            porta_liberada <= 1'b0;
            erro           <= 1'b0;
        end else begin
            state          <= state_next;
            tempo          <= tempo_next;
            vigia          <= vigia_next;
            control_port   <= cp_next;
            porta_liberada <= lib_next;
            erro           <= erro_next;
        end
    end

    assign estado = state;

endmodule

// File: tb/tb_controle_porta_elevador.sv
// tb/tb_controle_porta_elevador.sv - self-checking bench for controle_porta_elevador
module tb_controle_porta_elevador;

    localparam int TA = 8;
    localparam int TL = 16;

    logic       clock_in = 1'b0;
    logic       reset_n;
    logic       pedido_abrir, botao_abrir, botao_fechar, obstaculo;
    logic       port_a, port_f;
    logic       control_port, porta_liberada, erro;
    logic [2:0] estado;

    controle_porta_elevador #(.TEMPO_ABERTA(TA), .TEMPO_LIMITE(TL)) dut (
        .clock_in       (clock_in),
        .reset_n        (reset_n),
        .pedido_abrir   (pedido_abrir),
        .botao_abrir    (botao_abrir),
        .botao_fechar   (botao_fechar),
        .obstaculo      (obstaculo),
        .port_a         (port_a),
        .port_f         (port_f),
        .control_port   (control_port),
        .porta_liberada (porta_liberada),
        .erro           (erro),
        .estado         (estado)
    );

    always #5 clock_in = ~clock_in;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: phase plus edges elapsed since the phase (or dwell) started.
    int m_st;
    int m_e;
    // Door animation: position 0 = closed .. 4 = open.
    int pos;
    bit stuck;

    typedef struct {
        bit ped, ba, bf, ob, pa, pf;
        int est, cp, pl, er;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit reab;
        reab = pedido_abrir || botao_abrir || obstaculo;
        case (m_st)
            0: if (pedido_abrir || botao_abrir) begin m_st = 1; m_e = 0; end
               else if (!port_f) begin m_st = 3; m_e = 0; end
            1: if (port_a) begin m_st = 2; m_e = 0; end
               else begin m_e++; if (m_e == TL) m_st = 4; end
            2: if (reab) m_e = 0;
               else if (botao_fechar) begin m_st = 3; m_e = 0; end
               else begin m_e++; if (m_e == TA) begin m_st = 3; m_e = 0; end end
            3: if (reab) begin m_st = 1; m_e = 0; end
               else if (port_f) m_st = 0;
               else begin m_e++; if (m_e == TL) m_st = 4; end
            default: ;
        endcase
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_estado"}, int'(estado), m_st);
        chk({tag, "_control_port"}, int'(control_port), (m_st == 0 || m_st == 3) ? 1 : 0);
        chk({tag, "_porta_liberada"}, int'(porta_liberada), (m_st == 0) ? 1 : 0);
        chk({tag, "_erro"}, int'(erro), (m_st == 4) ? 1 : 0);
    endtask

    task automatic anim();
        if (!stuck) begin
            if (m_st == 0 || m_st == 3) begin
                if (pos > 0) pos--;
            end else if (pos < 4) begin
                pos++;
            end
        end
        port_a = (pos == 4);
        port_f = (pos == 0);
    endtask

    task automatic cyc();
        @(posedge clock_in);
        #1;
        model_step();
        check_model("model");
        anim();
    endtask

    task automatic clear_in();
        pedido_abrir = 0; botao_abrir = 0; botao_fechar = 0; obstaculo = 0;
    endtask

    // Asserted between clock edges, so output changes prove the reset is asynchronous.
    task automatic do_reset();
        #2;
        reset_n = 0;
        #1;
        m_st = 3;
        m_e  = 0;
        check_model("reset");
        @(negedge clock_in);
        reset_n = 1;
    endtask

    task automatic wait_state(input int st, input string tag);
        int n;
        n = 0;
        while (int'(estado) != st && n < 40) begin cyc(); n++; end
        chk(tag, int'(estado), st);
    endtask

    task automatic go_open();
        pedido_abrir = 1; cyc(); pedido_abrir = 0;
        wait_state(2, "reach_aberta");
    endtask

    initial begin
        int n;
        reset_n = 0;
        clear_in();
        stuck = 0;
        pos = 0;
        port_a = 0;
        port_f = 1;
        m_st = 3;
        m_e = 0;

        // ------------- table-driven vectors, door indicators driven directly
        tbl[0]  = '{0,0,0,0,0,1, 0,1,1,0};  // closed confirmed
        tbl[1]  = '{1,0,1,0,0,1, 1,0,0,0};  // pedido + fechar in FECHADA opens
        tbl[2]  = '{0,0,0,0,0,0, 1,0,0,0};  // still opening
        tbl[3]  = '{0,0,0,0,1,0, 2,0,0,0};  // fully open
        tbl[4]  = '{1,0,1,0,1,0, 2,0,0,0};  // reload wins over close button
        tbl[5]  = '{0,0,1,0,1,0, 3,1,0,0};  // close button
        tbl[6]  = '{0,0,0,0,1,1, 0,1,1,0};  // both indicators while closing: closed
        tbl[7]  = '{0,0,0,0,0,0, 3,1,0,0};  // door lost closed
        tbl[8]  = '{0,0,0,1,0,0, 1,0,0,0};  // obstacle reversal
        tbl[9]  = '{0,0,0,0,1,1, 2,0,0,0};  // both indicators while opening: open
        tbl[10] = '{0,0,1,0,1,0, 3,1,0,0};
        tbl[11] = '{0,1,0,0,0,0, 1,0,0,0};  // open button reverses

        @(posedge clock_in);
        #1;
        check_model("reset_init");
        @(negedge clock_in);
        reset_n = 1;
        for (int i = 0; i < 12; i++) begin
            pedido_abrir = tbl[i].ped; botao_abrir = tbl[i].ba;
            botao_fechar = tbl[i].bf;  obstaculo   = tbl[i].ob;
            port_a = tbl[i].pa;        port_f      = tbl[i].pf;
            @(posedge clock_in);
            #1;
            chk($sformatf("vec%0d_estado", i), int'(estado), tbl[i].est);
            chk($sformatf("vec%0d_control_port", i), int'(control_port), tbl[i].cp);
            chk($sformatf("vec%0d_porta_liberada", i), int'(porta_liberada), tbl[i].pl);
            chk($sformatf("vec%0d_erro", i), int'(erro), tbl[i].er);
        end
        clear_in();
        pos = 0; port_a = 0; port_f = 1;
        do_reset();
        chk("release_estado", int'(estado), 3);
        cyc();
        chk("release_fechada", int'(estado), 0);
        chk("release_liberada", int'(porta_liberada), 1);

        // ------------- dwell with no events
        pedido_abrir = 1; cyc(); pedido_abrir = 0;
        wait_state(2, "dwell_enter");
        n = 1;
        while (int'(estado) == 2 && n < 40) begin cyc(); n++; end
        chk("dwell_cycles", n - 1, TA);
        chk("dwell_next", int'(estado), 3);
        wait_state(0, "dwell_closed");

        // ------------- obstacle held at tempo=2, then full dwell
        go_open();
        repeat (5) cyc();
        obstaculo = 1;
        repeat (5) begin cyc(); chk("obst_hold", int'(estado), 2); end
        obstaculo = 0;
        n = 0;
        do begin cyc(); n++; end while (int'(estado) == 2 && n < 40);
        chk("obst_redwell", n, TA);

        // ------------- close button at tempo=6
        wait_state(0, "bf_closed");
        go_open();
        cyc();
        botao_fechar = 1; cyc(); botao_fechar = 0;
        chk("bf_fechando", int'(estado), 3);

        // ------------- reversal two cycles into FECHANDO
        repeat (2) cyc();
        obstaculo = 1; cyc(); obstaculo = 0;
        chk("rev_estado", int'(estado), 1);
        chk("rev_cp", int'(control_port), 0);
        wait_state(0, "rev_closed");

        // ------------- watchdog in ABRINDO
        stuck = 1;
        pedido_abrir = 1; cyc(); pedido_abrir = 0;
        n = 0;
        while (int'(estado) != 4 && n < 40) begin cyc(); n++; end
        chk("wd_edges", n, TL);
        chk("wd_cp", int'(control_port), 0);
        pedido_abrir = 1; botao_abrir = 1; botao_fechar = 1;
        repeat (3) cyc();
        clear_in();
        chk("wd_absorb", int'(erro), 1);
        stuck = 0;
        do_reset();
        chk("wd_reset_erro", int'(erro), 0);
        wait_state(0, "wd_closed");

        // ------------- async reset mid-ABERTA at tempo=5
        go_open();
        repeat (2) cyc();
        do_reset();
        chk("async_estado", int'(estado), 3);
        chk("async_cp", int'(control_port), 1);

        // ------------- randomized stimulus against the model
        for (int k = 0; k < 3000; k++) begin
            pedido_abrir = ($urandom_range(0, 19) == 0);
            botao_abrir  = ($urandom_range(0, 39) == 0);
            botao_fechar = ($urandom_range(0, 14) == 0);
            obstaculo    = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 99) == 0) stuck = ~stuck;
            cyc();
            if ((m_st == 4 && $urandom_range(0, 9) == 0) || $urandom_range(0, 499) == 0) begin
                clear_in();
                do_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: actual running required finished");
        $fatal(1, "timeout");
    end

endmodule
